// File: rtl/serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx
// Serial-to-parallel receiver with comma (BC_CHAR) byte alignment.
// Bits arrive MSB first, one per clk_32f cycle. The receiver looks for
// BC_CHAR at any bit offset. It then locks onto that byte boundary, and
// goes active once BC_COUNT consecutive aligned BC_CHAR bytes are seen.
// While active, non-comma bytes are presented on data_out with a one-cycle
// valid_out strobe. Comma bytes only raise idle_out.
//
// Ports
//   clk_32f   : bit clock, all state updates on its rising edge
//   reset     : synchronous active-high reset
//   data_in   : serial line, one bit per cycle, MSB of each byte first
//   data_out  : last received non-comma byte (registered)
//   valid_out : one-cycle strobe marking a new data_out byte
//   active    : link aligned and active (sticky until reset)
//   idle_out  : while active, last completed byte was BC_CHAR
// ---------------------------------------------------------------------------
module serial_paralelo_rx #(
    parameter logic [7:0]  BC_CHAR  = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       idle_out
);

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned BC_CNT_W  = 4;

    localparam logic [BC_CNT_W-1:0]  BC_TARGET = BC_CNT_W'(BC_COUNT);
    localparam logic [BC_CNT_W-1:0]  BC_MAX    = '1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = '1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                state;
    logic [BYTE_W-1:0]     shift_q;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BC_CNT_W-1:0]   bc_cnt;

    logic [BYTE_W-1:0]     word_next;
    logic                  byte_done;
    logic                  is_bc;
    logic [BC_CNT_W-1:0]   bc_inc;

    // The byte as it will look once the current bit is shifted in.
    assign word_next = {shift_q[BYTE_W-2:0], data_in};
    assign byte_done = (bit_cnt == LAST_BIT);
    assign is_bc     = (word_next == BC_CHAR);
    // Saturating increment so a long comma run can never wrap the count.
    assign bc_inc    = (bc_cnt == BC_MAX) ? bc_cnt : bc_cnt + BC_CNT_W'(1);

    // Alignment FSM with registered outputs. Outputs are updated on the same
    // edge that samples the last bit of a byte.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= ST_SEARCH;
            shift_q   <= '0;
            bit_cnt   <= '0;
            bc_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            idle_out  <= 1'b0;
        end else begin
            shift_q   <= word_next;
            valid_out <= 1'b0;

            case (state)
                // Bit-offset-agnostic hunt for the comma character.
                ST_SEARCH: begin
                    if (is_bc) begin
                        bit_cnt <= '0;
                        bc_cnt  <= BC_CNT_W'(1);
                        if (BC_TARGET == BC_CNT_W'(1)) begin
                            state  <= ST_ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ST_ALIGN;
                        end
                    end
                end

                // Only byte-aligned commas count; anything else drops the lock.
                ST_ALIGN: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (byte_done) begin
                        if (is_bc) begin
                            bc_cnt <= bc_inc;
                            if (bc_inc == BC_TARGET) begin
                                state  <= ST_ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= '0;
                            state  <= ST_SEARCH;
                        end
                    end
                end

                // Sticky; commas at unaligned offsets are just data bits.
                ST_ACTIVE: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (byte_done) begin
                        if (is_bc) begin
                            idle_out <= 1'b1;
                        end else begin
                            data_out  <= word_next;
                            valid_out <= 1'b1;
                            idle_out  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= ST_SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Directed testbench for serial_paralelo_rx with the default parameters
// (BC_CHAR = 8'hBC, BC_COUNT = 4). Bits are driven on the falling edge.
// Outputs are sampled 1 time unit after the rising edge that consumed the bit.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_rx;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       idle_out;

    int checks;
    int fails;
    int byte_valid;   // valid_out pulses seen during the last send_byte
    logic act_pre;    // active after bit 7 of the last send_byte

    serial_paralelo_rx #(
        .BC_CHAR  (8'hBC),
        .BC_COUNT (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .idle_out  (idle_out)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 0;
        act_pre    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (valid_out === 1'b1) byte_valid++;
            if (i == 1) act_pre = active;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset   = 1'b1;
        data_in = 1'b0;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", active); end
        checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL reset_idle: got %b expected 0", idle_out); end
    endtask

    // Four aligned commas from a clean start: active on the 32nd bit edge.
    task automatic test_basic_align();
        int vsum;
        vsum = 0;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            send_byte(8'hBC);
            vsum += byte_valid;
            if (n < 3) begin
                checks++; if (active !== 1'b0) begin fails++; $display("FAIL basic_active_early byte %0d: got %b expected 0", n, active); end
            end
        end
        checks++; if (act_pre !== 1'b0) begin fails++; $display("FAIL basic_active_bit31: got %b expected 0", act_pre); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL basic_active_bit32: got %b expected 1", active); end
        checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL basic_idle_on_entry: got %b expected 0", idle_out); end
        send_byte(8'hBC);
        vsum += byte_valid;
        checks++; if (idle_out !== 1'b1) begin fails++; $display("FAIL basic_idle_after_bc: got %b expected 1", idle_out); end
        checks++; if (vsum != 0) begin fails++; $display("FAIL basic_no_valid: got %0d pulses expected 0", vsum); end
    endtask

    // Junk bits shift the byte boundary; alignment follows the first comma.
    task automatic test_junk_align();
        int vsum;
        vsum = 0;
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int n = 0; n < 5; n++) begin
            send_byte(8'hBC);
            vsum += byte_valid;
            if (n == 2) begin
                checks++; if (active !== 1'b0) begin fails++; $display("FAIL junk_active_after_3: got %b expected 0", active); end
            end
            if (n == 3) begin
                checks++; if (act_pre !== 1'b0) begin fails++; $display("FAIL junk_active_pre_4: got %b expected 0", act_pre); end
                checks++; if (active !== 1'b1) begin fails++; $display("FAIL junk_active_after_4: got %b expected 1", active); end
                checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL junk_idle_after_4: got %b expected 0", idle_out); end
            end
        end
        checks++; if (idle_out !== 1'b1) begin fails++; $display("FAIL junk_idle_after_5: got %b expected 1", idle_out); end
        checks++; if (vsum != 0) begin fails++; $display("FAIL junk_no_valid: got %0d pulses expected 0", vsum); end
    endtask

    // Back-to-back data bytes followed by a comma.
    task automatic test_data_bytes();
        do_reset();
        for (int n = 0; n < 4; n++) send_byte(8'hBC);
        send_byte(8'hA5);
        checks++; if (data_out !== 8'hA5) begin fails++; $display("FAIL data_a5: got %h expected a5", data_out); end
        checks++; if (valid_out !== 1'b1) begin fails++; $display("FAIL data_a5_valid: got %b expected 1", valid_out); end
        checks++; if (byte_valid != 1) begin fails++; $display("FAIL data_a5_pulses: got %0d expected 1", byte_valid); end
        send_byte(8'h3C);
        checks++; if (data_out !== 8'h3C) begin fails++; $display("FAIL data_3c: got %h expected 3c", data_out); end
        checks++; if (valid_out !== 1'b1) begin fails++; $display("FAIL data_3c_valid: got %b expected 1", valid_out); end
        checks++; if (byte_valid != 1) begin fails++; $display("FAIL data_3c_pulses: got %0d expected 1", byte_valid); end
        checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL data_3c_idle: got %b expected 0", idle_out); end
        send_byte(8'hBC);
        checks++; if (idle_out !== 1'b1) begin fails++; $display("FAIL data_bc_idle: got %b expected 1", idle_out); end
        checks++; if (data_out !== 8'h3C) begin fails++; $display("FAIL data_bc_hold: got %h expected 3c", data_out); end
        checks++; if (byte_valid != 0) begin fails++; $display("FAIL data_bc_pulses: got %0d expected 0", byte_valid); end
    endtask

    // A non-comma byte during alignment drops back to search.
    task automatic test_realign();
        int vsum;
        vsum = 0;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            send_byte(8'hBC);
            vsum += byte_valid;
        end
        send_byte(8'h00);
        vsum += byte_valid;
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL realign_after_00: got %b expected 0", active); end
        for (int n = 0; n < 4; n++) begin
            send_byte(8'hBC);
            vsum += byte_valid;
            if (n == 2) begin
                checks++; if (active !== 1'b0) begin fails++; $display("FAIL realign_after_3: got %b expected 0", active); end
            end
        end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL realign_after_4: got %b expected 1", active); end
        checks++; if (vsum != 0) begin fails++; $display("FAIL realign_no_valid: got %0d pulses expected 0", vsum); end
    endtask

    // Reset in the middle of a byte while active discards the partial byte.
    task automatic test_reset_mid_byte();
        int vsum;
        logic [7:0] v55;
        vsum = 0;
        v55  = 8'h55;
        do_reset();
        for (int n = 0; n < 4; n++) send_byte(8'hBC);
        send_byte(8'h81);
        send_byte(8'hBC);
        checks++; if (idle_out !== 1'b1 || data_out !== 8'h81) begin fails++; $display("FAIL midrst_setup: got idle %b data %h expected 1 81", idle_out, data_out); end
        for (int i = 7; i >= 4; i--) send_bit(v55[i]);
        do_reset();
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", data_out); end
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL midrst_active: got %b expected 0", active); end
        checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL midrst_idle: got %b expected 0", idle_out); end
        checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
        for (int i = 3; i >= 0; i--) begin
            send_bit(v55[i]);
            if (valid_out === 1'b1) vsum++;
        end
        checks++; if (vsum != 0 || data_out !== 8'h00) begin fails++; $display("FAIL midrst_no_emit: got %0d pulses data %h expected 0 00", vsum, data_out); end
        for (int n = 0; n < 4; n++) begin
            send_byte(8'hBC);
            if (n == 2) begin
                checks++; if (active !== 1'b0) begin fails++; $display("FAIL midrst_search_3: got %b expected 0", active); end
            end
        end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL midrst_search_4: got %b expected 1", active); end
    endtask

    // A comma pattern straddling a byte boundary is treated as data.
    task automatic test_straddle();
        do_reset();
        for (int n = 0; n < 5; n++) send_byte(8'hBC);
        send_byte(8'h0B);
        checks++; if (data_out !== 8'h0B || byte_valid != 1) begin fails++; $display("FAIL straddle_0b: got data %h pulses %0d expected 0b 1", data_out, byte_valid); end
        checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL straddle_0b_idle: got %b expected 0", idle_out); end
        send_byte(8'hC0);
        checks++; if (data_out !== 8'hC0 || byte_valid != 1) begin fails++; $display("FAIL straddle_c0: got data %h pulses %0d expected c0 1", data_out, byte_valid); end
        checks++; if (idle_out !== 1'b0) begin fails++; $display("FAIL straddle_c0_idle: got %b expected 0", idle_out); end
        send_byte(8'hA5);
        checks++; if (data_out !== 8'hA5 || byte_valid != 1) begin fails++; $display("FAIL straddle_keep_align: got data %h pulses %0d expected a5 1", data_out, byte_valid); end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        reset   = 1'b1;
        data_in = 1'b0;
        test_reset();
        test_basic_align();
        test_junk_align();
        test_data_bytes();
        test_realign();
        test_reset_mid_byte();
        test_straddle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 SHALL have parameter BC_CHAR, default 8'hBC: idle/comma character used for alignment and idle signalling.
REQ-002 SHALL have parameter BC_COUNT, default 4: number of consecutive aligned BC_CHAR bytes needed to go active (legal range 1..15).
REQ-003 SHALL have port clk_32f  input  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  1: serial line, one bit per clk_32f cycle, MSB of each byte first.
REQ-006 SHALL have port data_out  output  8: last received non-BC byte, registered.
REQ-007 SHALL have port valid_out  output  1: one-cycle strobe marking a new data_out byte.
REQ-008 SHALL have port active  output  1: link aligned and active, registered.
REQ-009 SHALL have port idle_out  output  1: while active, last completed byte was BC_CHAR, registered.

Function
REQ-010 SHALL shift data_in into an 8-bit register every cycle, MSB first; word_next = {shift[6:0], data_in}.
REQ-011 SHALL implement a state machine with states SEARCH, ALIGN, ACTIVE, plus a 3-bit bit counter and a 4-bit BC counter.
REQ-012 A byte SHALL be complete in a cycle when the bit counter equals 7; the bit counter wraps 7->0.
REQ-013 In SEARCH, word_next is checked every cycle, independent of the bit counter; on a match with BC_CHAR: bit counter <= 0, BC counter <= 1, go to ALIGN. If BC_COUNT==1, go directly to ACTIVE instead.
REQ-014 In ALIGN, the bit counter increments every cycle.
REQ-015 In ALIGN, on byte complete with word_next==BC_CHAR: BC counter increments; if the new count equals BC_COUNT, go to ACTIVE and active <= 1 in the same edge.
REQ-016 In ALIGN, on byte complete with word_next!=BC_CHAR: BC counter <= 0, go to SEARCH, and no valid_out is produced.
REQ-017 In ACTIVE, on byte complete with word_next!=BC_CHAR: data_out <= word_next, valid_out <= 1 for exactly one cycle, idle_out <= 0.
REQ-018 In ACTIVE, on byte complete with word_next==BC_CHAR: idle_out <= 1, valid_out <= 0, and data_out holds its value.
REQ-019 valid_out SHALL be 0 in every cycle other than those given in REQ-017; it is never asserted outside ACTIVE.
REQ-020 Latency: the last bit of a byte is sampled at edge k, and data_out/valid_out/idle_out update at edge k (zero extra pipeline cycles).
REQ-021 ACTIVE SHALL be sticky; it is left only by reset.
REQ-022 A BC_CHAR pattern at an unaligned offset while in ALIGN or ACTIVE SHALL be ignored.
REQ-023 The BC counter SHALL saturate and never wrap.

Reset
REQ-024 When reset=1 at an edge: state <= SEARCH, shift register <= 0, both counters <= 0, data_out <= 8'h00, valid_out <= 0, active <= 0, idle_out <= 0.
REQ-025 Reset SHALL take priority over all other events, including a byte completing in the same cycle; any partial byte is discarded.
REQ-026 After reset is released, the first edge SHALL resume operation in SEARCH.

Verification
REQ-027 Reset, then 4 aligned 8'hBC bytes -> active=1 after the 32nd bit edge; valid_out=0 throughout; idle_out=0 until the next BC byte.
REQ-028 Reset, 3 junk bits (1,0,1), then 5 8'hBC bytes -> alignment after the first BC; active=1 at the edge of the last bit of the 4th BC; idle_out=1 after the 5th BC.
REQ-029 Active, then 8'hA5, 8'h3C, 8'hBC -> data_out=A5 with valid_out pulse, then 3C with pulse; after the BC, idle_out=1 and data_out stays 3C.
REQ-030 Reset, 3 BCs, 8'h00, 4 BCs -> return to SEARCH after 8'h00 with active=0; active=1 only at the end of the second BC run.
REQ-031 Active mid-byte (bit 4 of 8'h55), reset held for 1 cycle -> next cycle all outputs 0 and state SEARCH; the partial byte is never emitted.
REQ-032 Active, serial stream containing 8'hBC straddling a byte boundary (e.g. 8'h0B, 8'hC0) -> both bytes emitted with valid_out, no realignment, idle_out=0.
